// File: rtl/fetch_unit.sv
// Fetch-side producer for the IF/ID register: owns the PC, runs a req/ack instruction-memory handshake.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds FetchMisalign and a terminal trap on misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValid,
  output logic        FetchStallReq
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        FetchMisalign
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        discard;
  logic        imem_req;
  logic        fetch_valid;
  logic [31:0] instr_f;
  logic [31:0] pcf;
  logic [31:0] pcplus4f;
  logic [31:0] redir_tgt;
  logic [31:0] pc_seq;

  assign redir_tgt = PCTargetE & ~32'h0000_0003;
  assign pc_seq    = pc + STEP;

  // The request address is the PC register itself, so it cannot move while a request waits.
  assign IMemReq       = imem_req;
  assign IMemAddr      = pc;
  assign InstrF        = instr_f;
  assign PCF           = pcf;
  assign PCPlus4F      = pcplus4f;
  assign FetchValid    = fetch_valid;
  assign FetchStallReq = imem_req & ~IMemAck;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misalign;
  logic trap_redirect;

  assign FetchMisalign = fetch_misalign;
  assign trap_redirect = PCSrcE && (PCTargetE[1:0] != 2'b00) && (state != S_TRAP);
`endif

  // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      pend_target <= 32'h0;
      discard     <= 1'b0;
      imem_req    <= 1'b0;
      fetch_valid <= 1'b0;
      instr_f     <= NOP;
      pcf         <= RESET_PC;
      pcplus4f    <= RESET_PC + STEP;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    else if (trap_redirect) begin
      state          <= S_TRAP;
      fetch_misalign <= 1'b1;
      imem_req       <= 1'b0;
      fetch_valid    <= 1'b0;
      discard        <= 1'b0;
      pcf            <= PCTargetE;
    end
`endif
    else begin
      case (state)
        S_REQ: begin
          if (PCSrcE) begin
            // Any data acked alongside the redirect is wrong-path and dropped.
            pc          <= redir_tgt;
            imem_req    <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (imem_req && IMemAck) begin
            instr_f     <= IMemRData;
            pcf         <= pc;
            pcplus4f    <= pc_seq;
            fetch_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end else if (imem_req) begin
            state <= S_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (IMemAck) begin
            discard <= 1'b0;
            if (PCSrcE) begin
              pc    <= redir_tgt;
              state <= S_REQ;
            end else if (discard) begin
              pc    <= pend_target;
              state <= S_REQ;
            end else begin
              instr_f     <= IMemRData;
              pcf         <= pc;
              pcplus4f    <= pc_seq;
              fetch_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= S_HOLD;
            end
          end else if (PCSrcE) begin
            pend_target <= redir_tgt;
            discard     <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSrcE) begin
            pc          <= redir_tgt;
            imem_req    <= 1'b1;
            fetch_valid <= 1'b0;
            state       <= S_REQ;
          end else if (!StallF) begin
            pc          <= pc_seq;
            imem_req    <= 1'b1;
            fetch_valid <= 1'b0;
            state       <= S_REQ;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: handshake, stalls, redirects, PC wrap and reset.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FetchValid;
  logic        FetchStallReq;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        FetchMisalign;
`endif

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .StallF       (StallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRData    (IMemRData),
    .InstrF       (InstrF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .FetchValid   (FetchValid),
    .FetchStallReq(FetchStallReq)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .FetchMisalign(FetchMisalign)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic zw_fetch(input logic [31:0] data);
    IMemAck   = 1'b1;
    IMemRData = data;
    tick();
    IMemAck   = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    RST = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    IMemAck = 1'b0; IMemRData = 32'h0;
    repeat (2) tick();
    checks++;
    if ({IMemReq, IMemAddr, FetchValid, FetchStallReq} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b stall=%b, expected 0/00000000/0/0",
               IMemReq, IMemAddr, FetchValid, FetchStallReq);
    end
    checks++;
    if ({InstrF, PCF, PCPlus4F} !== {32'h13, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reset_data: instr=%h pcf=%h pc4=%h, expected 00000013/00000000/00000004",
               InstrF, PCF, PCPlus4F);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait;
    logic [31:0] words [3];
    words = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({IMemReq, IMemAddr, FetchValid} !== {1'b1, 32'(4 * i), 1'b0}) begin
        errors++;
        $display("FAIL zw_req%0d: req=%b addr=%h valid=%b, expected 1/%h/0",
                 i, IMemReq, IMemAddr, FetchValid, 32'(4 * i));
      end
      IMemAck = 1'b1; IMemRData = words[i];
      #1;
      checks++;
      if (FetchStallReq !== 1'b0) begin
        errors++;
        $display("FAIL zw_stall%0d: stall=%b expected 0", i, FetchStallReq);
      end
      tick();
      IMemAck = 1'b0; IMemRData = 32'h0;
      checks++;
      if ({FetchValid, IMemReq, InstrF, PCF, PCPlus4F} !==
          {1'b1, 1'b0, words[i], 32'(4 * i), 32'(4 * i + 4)}) begin
        errors++;
        $display("FAIL zw_cap%0d: valid=%b req=%b instr=%h pcf=%h pc4=%h, expected 1/0/%h/%h/%h",
                 i, FetchValid, IMemReq, InstrF, PCF, PCPlus4F, words[i], 32'(4 * i), 32'(4 * i + 4));
      end
      tick();
    end
  endtask

  task automatic test_wait_states;
    int held    = 0;
    int stalled = 0;
    zw_fetch(32'h0040_0213);
    for (int c = 0; c < 4; c++) begin
      IMemAck   = (c == 3);
      IMemRData = (c == 3) ? 32'hDEAD_0013 : 32'h0;
      #1;
      if (IMemReq && IMemAddr == 32'h10) held++;
      if (FetchStallReq) stalled++;
      tick();
    end
    IMemAck = 1'b0;
    checks++;
    if (held !== 4 || stalled !== 3) begin
      errors++;
      $display("FAIL wait_cycles: addr held %0d stall %0d, expected 4 and 3", held, stalled);
    end
    checks++;
    if ({FetchValid, InstrF, PCF} !== {1'b1, 32'hDEAD_0013, 32'h10}) begin
      errors++;
      $display("FAIL wait_cap: valid=%b instr=%h pcf=%h, expected 1/dead0013/00000010",
               FetchValid, InstrF, PCF);
    end
    tick();
    checks++;
    if ({IMemReq, IMemAddr} !== {1'b1, 32'h14}) begin
      errors++;
      $display("FAIL wait_next: req=%b addr=%h, expected 1/00000014", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_stall;
    zw_fetch(32'h1); zw_fetch(32'h2); zw_fetch(32'h3);
    IMemAck = 1'b1; IMemRData = 32'h0200_0513;
    tick();
    IMemAck = 1'b0; StallF = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({FetchValid, IMemReq, InstrF, PCF, PCPlus4F} !==
          {1'b1, 1'b0, 32'h0200_0513, 32'h20, 32'h24}) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b req=%b instr=%h pcf=%h pc4=%h, expected 1/0/02000513/20/24",
                 c, FetchValid, IMemReq, InstrF, PCF, PCPlus4F);
      end
      tick();
    end
    StallF = 1'b0;
    tick();
    checks++;
    if ({IMemReq, IMemAddr, FetchValid} !== {1'b1, 32'h24, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, expected 1/00000024/0",
               IMemReq, IMemAddr, FetchValid);
    end
  endtask

  task automatic test_redirect;
    IMemAck = 1'b1; IMemRData = 32'h0000_0BAD;
    tick();
    IMemAck = 1'b0;
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    StallF = 1'b0; PCSrcE = 1'b0;
    checks++;
    if ({IMemReq, IMemAddr, FetchValid} !== {1'b1, 32'h40, 1'b0}) begin
      errors++;
      $display("FAIL redir_hold: req=%b addr=%h valid=%b, expected 1/00000040/0",
               IMemReq, IMemAddr, FetchValid);
    end
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    checks++;
    if ({IMemReq, IMemAddr, FetchStallReq, FetchValid} !== {1'b1, 32'h40, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL redir_wait_stable: req=%b addr=%h stall=%b valid=%b, expected 1/00000040/1/0",
               IMemReq, IMemAddr, FetchStallReq, FetchValid);
    end
    IMemAck = 1'b1; IMemRData = 32'hBAD0_0BAD;
    tick();
    IMemAck = 1'b0;
    checks++;
    if ({FetchValid, IMemReq, IMemAddr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++;
      $display("FAIL redir_drop: valid=%b req=%b addr=%h, expected 0/1/00000100",
               FetchValid, IMemReq, IMemAddr);
    end
    IMemAck = 1'b1; IMemRData = 32'h0000_0517;
    tick();
    IMemAck = 1'b0;
    checks++;
    if ({FetchValid, InstrF, PCF, PCPlus4F} !== {1'b1, 32'h0000_0517, 32'h100, 32'h104}) begin
      errors++;
      $display("FAIL redir_cap: valid=%b instr=%h pcf=%h pc4=%h, expected 1/00000517/100/104",
               FetchValid, InstrF, PCF, PCPlus4F);
    end
    tick();
  endtask

  task automatic test_redirect_ack_same_cycle;
    tick();
    IMemAck = 1'b1; IMemRData = 32'h0BAD_0BAD; PCSrcE = 1'b1; PCTargetE = 32'h300;
    tick();
    IMemAck = 1'b0; PCSrcE = 1'b0;
    checks++;
    if ({FetchValid, IMemReq, IMemAddr} !== {1'b0, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL redir_ack_same: valid=%b req=%b addr=%h, expected 0/1/00000300",
               FetchValid, IMemReq, IMemAddr);
    end
  endtask

  task automatic test_wrap;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    checks++;
    if ({IMemReq, IMemAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h, expected 1/fffffffc", IMemReq, IMemAddr);
    end
    IMemAck = 1'b1; IMemRData = 32'h0000_0073;
    tick();
    IMemAck = 1'b0;
    checks++;
    if ({FetchValid, PCF, PCPlus4F} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_cap: valid=%b pcf=%h pc4=%h, expected 1/fffffffc/00000000",
               FetchValid, PCF, PCPlus4F);
    end
    tick();
    checks++;
    if ({IMemReq, IMemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h, expected 1/00000000", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_misalign;
    IMemAck = 1'b1; IMemRData = 32'h0000_0013;
    tick();
    IMemAck = 1'b0;
    PCSrcE = 1'b1; PCTargetE = 32'h102;
    tick();
    PCSrcE = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if ({FetchMisalign, IMemReq, FetchValid, FetchStallReq, PCF} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h102}) begin
      errors++;
      $display("FAIL trap_enter: mis=%b req=%b valid=%b stall=%b pcf=%h, expected 1/0/0/0/00000102",
               FetchMisalign, IMemReq, FetchValid, FetchStallReq, PCF);
    end
    for (int c = 0; c < 4; c++) begin
      IMemAck = c[0]; PCSrcE = c[1]; PCTargetE = 32'h200;
      tick();
      checks++;
      if ({FetchMisalign, IMemReq, FetchValid} !== {1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL trap_stay%0d: mis=%b req=%b valid=%b, expected 1/0/0",
                 c, FetchMisalign, IMemReq, FetchValid);
      end
    end
    IMemAck = 1'b0; PCSrcE = 1'b0;
`else
    checks++;
    if ({IMemReq, IMemAddr, FetchValid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL misalign_mask: req=%b addr=%h valid=%b, expected 1/00000100/0",
               IMemReq, IMemAddr, FetchValid);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({IMemReq, IMemAddr, FetchValid, FetchStallReq, InstrF, PCF, PCPlus4F} !==
        {1'b0, 32'h0, 1'b0, 1'b0, 32'h13, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reset_mid: req=%b addr=%h valid=%b stall=%b instr=%h pcf=%h pc4=%h",
               IMemReq, IMemAddr, FetchValid, FetchStallReq, InstrF, PCF, PCPlus4F);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (FetchMisalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: mis=%b expected 0", FetchMisalign);
    end
`endif
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({IMemReq, IMemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_restart: req=%b addr=%h, expected 1/00000000", IMemReq, IMemAddr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect();
    test_redirect_ack_same_cycle();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
